// File: rtl/dm_defs.sv
// Shared definitions for the data-memory responder.
// Size codes and FSM state encoding.
package dm_defs;

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte/half/word lane selection, store merge and load extension.
// Purely combinational; flags lane misalignment.
module dm_lane_unit
   import dm_defs::*;
(
   input  logic [31:0] old_word,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   output logic [31:0] merged_word,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [7:0]  b_sel;
   logic [15:0] h_sel;

   // Lane select, merge and extend by access size
   always_comb begin
      merged_word = old_word;
      load_data   = '0;
      misalign    = 1'b0;
      b_sel       = old_word[{addr, 3'b000} +: 8];
      h_sel       = addr[1] ? old_word[31:16] : old_word[15:0];
      unique case (size)
         SIZE_B: begin
            merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
            load_data = sign ? {{24{b_sel[7]}}, b_sel}
                             : {24'b0, b_sel};
         end
         SIZE_H: begin
            misalign = addr[0];
            if (addr[1]) merged_word[31:16] = wdata[15:0];
            else         merged_word[15:0]  = wdata[15:0];
            load_data = sign ? {{16{h_sel[15]}}, h_sel}
                             : {16'b0, h_sel};
         end
         SIZE_W: begin
            misalign    = (addr != 2'b00);
            merged_word = wdata;
            load_data   = old_word;
         end
         default: begin
            merged_word = old_word;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: FSM, latency counter, word array.
// Store trace is compiled only when DM_TRACE_EN is defined.
module data_mem_responder
   import dm_defs::*;
#(
   parameter int DEPTH_WORDS = 3072,
   parameter int ADDR_W      = 12,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   dm_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [ADDR_W-1:0] idx;
   logic        oor;
   logic        err;
   logic        access;
   logic        wr_en;
   logic [31:0] old_word;
   logic [31:0] merged_word;
   logic [31:0] load_data;
   logic        misalign;

   dm_lane_unit u_lane (
      .old_word   (old_word),
      .addr       (addr_q[1:0]),
      .size       (size_q),
      .sign       (sign_q),
      .wdata      (wdata_q),
      .merged_word(merged_word),
      .load_data  (load_data),
      .misalign   (misalign)
   );

   // Address decode, range check and write enable
   always_comb begin
      idx = addr_q[ADDR_W+1:2];
      oor = ({{(32-ADDR_W){1'b0}}, idx} >= 32'(DEPTH_WORDS))
          || (addr_q[31:ADDR_W+2] != '0);
      old_word = oor ? 32'h0 : mem_q[idx];
      err    = (size_q == SIZE_RSV) || misalign || oor;
      access = (state_q == WAIT) && (cnt_q == 4'd0);
      wr_en  = access && we_q && !err;
   end

   // Next-state, request latch and response capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      pc_d    = pc_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               sign_d  = req_sign;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               pc_d    = req_pc;
               cnt_d   = 4'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               rdata_d = (err || we_q) ? 32'h0 : load_data;
               err_d   = err;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and request registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SIZE_B;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         pc_q    <= pc_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Memory array: cleared on reset, written on the RESP-entry edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[idx] <= merged_word;
      end
   end

`ifdef DM_TRACE_EN
   // Store trace on each successful write
   always_ff @(posedge clk) begin
      if (reset && wr_en)
         $display("@%h: *%h <= %h", pc_q,
                  {addr_q[31:2], 2'b00}, merged_word);
   end
`else
`endif

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: u1 LATENCY=1, u3 LATENCY=3.
// Expected responses queued, popped on rsp_valid.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_sign  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] req_pc    [2];
  logic        rsp_ready [2];
  logic        rdy_o [2];
  logic        vld_o [2];
  logic [31:0] rd_o  [2];
  logic        err_o [2];
  logic        busy_o [2];

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input bit ok,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  data_mem_responder #(
    .DEPTH_WORDS(3072), .ADDR_W(12), .LATENCY(1)
  ) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(rdy_o[0]),
    .req_we(req_we[0]), .req_size(req_size[0]),
    .req_sign(req_sign[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
    .rsp_valid(vld_o[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rd_o[0]), .rsp_err(err_o[0]),
    .busy(busy_o[0])
  );

  data_mem_responder #(
    .DEPTH_WORDS(3072), .ADDR_W(12), .LATENCY(3)
  ) u3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(rdy_o[1]),
    .req_we(req_we[1]), .req_size(req_size[1]),
    .req_sign(req_sign[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
    .rsp_valid(vld_o[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rd_o[1]), .rsp_err(err_o[1]),
    .busy(busy_o[1])
  );

  task automatic drive(input int w, input logic we,
                       input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [31:0] pc);
    req_valid[w] = 1'b1;
    req_we[w]    = we;
    req_size[w]  = sz;
    req_sign[w]  = sg;
    req_addr[w]  = a;
    req_wdata[w] = d;
    req_pc[w]    = pc;
  endtask

  task automatic txn(input int w, input logic we,
                     input logic [1:0] sz,
                     input logic sg, input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] pc,
                     input logic [31:0] erd,
                     input logic eerr,
                     input int hold, input bit inject);
    int n;
    int lat;
    int el;
    exp_t e;
    n = 0;
    while (!rdy_o[w] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_idle", rdy_o[w] === 1'b1,
        rdy_o[w], 1'b1);
    drive(w, we, sz, sg, a, d, pc);
    sb.push_back('{rd: erd, err: eerr});
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    chk("busy_after_accept", busy_o[w] === 1'b1,
        busy_o[w], 1'b1);
    lat = 0;
    while (!vld_o[w] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    el = (w == 0) ? 1 : 3;
    chk("latency", lat == el, lat, el);
    for (int h = 0; h < hold; h++) begin
      if (inject)
        drive(w, 1'b1, 2'b10, 1'b0, a,
              32'h11111111, 32'h0);
      chk("req_ready_in_resp", rdy_o[w] === 1'b0,
          rdy_o[w], 1'b0);
      @(posedge clk); #1;
      chk("rsp_valid_held", vld_o[w] === 1'b1,
          vld_o[w], 1'b1);
      if (sb.size() > 0)
        chk("rdata_stable", rd_o[w] === sb[0].rd,
            rd_o[w], sb[0].rd);
    end
    req_valid[w] = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 1'b0, 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rd_o[w] === e.rd,
          rd_o[w], e.rd);
      chk("rsp_err", err_o[w] === e.err,
          err_o[w], e.err);
    end
    rsp_ready[w] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[w] = 1'b0;
    chk("rsp_valid_drop", vld_o[w] === 1'b0,
        vld_o[w], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_size[i] = 2'b00; req_sign[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
      req_pc[i] = '0; rsp_ready[i] = 1'b0;
    end
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", rdy_o[0] === 1'b1,
        rdy_o[0], 1'b1);
    chk("rst_rsp_valid", vld_o[0] === 1'b0,
        vld_o[0], 1'b0);
    chk("rst_rdata", rd_o[0] === 32'h0,
        rd_o[0], 32'h0);
    chk("rst_err", err_o[0] === 1'b0,
        err_o[0], 1'b0);
    chk("rst_busy", busy_o[0] === 1'b0,
        busy_o[0], 1'b0);
    chk("rst_busy3", busy_o[1] === 1'b0,
        busy_o[1], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    txn(0, 1, 2'b10, 0, 32'h10, 32'h12345678,
        32'h100, 32'h0, 0, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0,
        32'h104, 32'h12345678, 0, 0, 0);
    txn(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFFAB,
        32'h108, 32'h0, 0, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0,
        32'h10C, 32'h1234AB78, 0, 0, 0);
    txn(0, 0, 2'b00, 1, 32'h11, 32'h0,
        32'h110, 32'hFFFFFFAB, 0, 0, 0);
    txn(0, 0, 2'b00, 0, 32'h11, 32'h0,
        32'h114, 32'h000000AB, 0, 0, 0);
    txn(0, 0, 2'b01, 1, 32'h10, 32'h0,
        32'h118, 32'hFFFFAB78, 0, 0, 0);
    txn(0, 0, 2'b01, 0, 32'h12, 32'h0,
        32'h11C, 32'h00001234, 0, 0, 0);
    txn(0, 1, 2'b01, 0, 32'h12, 32'h0000BEEF,
        32'h120, 32'h0, 0, 0, 0);
    txn(0, 0, 2'b01, 1, 32'h12, 32'h0,
        32'h124, 32'hFFFFBEEF, 0, 0, 0);
    txn(0, 1, 2'b01, 0, 32'h13, 32'h00005555,
        32'h128, 32'h0, 1, 0, 0);
    txn(0, 1, 2'b10, 0, 32'h12, 32'h66666666,
        32'h12C, 32'h0, 1, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h16, 32'h0,
        32'h130, 32'h0, 1, 0, 0);
    txn(0, 0, 2'b11, 0, 32'h0, 32'h0,
        32'h134, 32'h0, 1, 0, 0);
    txn(0, 1, 2'b10, 0, 32'h3000, 32'h77777777,
        32'h138, 32'h0, 1, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h00010010, 32'h0,
        32'h13C, 32'h0, 1, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0,
        32'h140, 32'hBEEFAB78, 0, 0, 0);
    txn(0, 1, 2'b10, 0, 32'h2FFC, 32'hA5A5C3C3,
        32'h144, 32'h0, 0, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h2FFC, 32'h0,
        32'h148, 32'hA5A5C3C3, 0, 0, 0);

    txn(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D,
        32'h200, 32'h0, 0, 0, 0);
    txn(1, 0, 2'b10, 0, 32'h20, 32'h0,
        32'h204, 32'hCAFEF00D, 0, 4, 1);
    txn(1, 0, 2'b10, 0, 32'h20, 32'h0,
        32'h208, 32'hCAFEF00D, 0, 0, 0);

    drive(1, 1'b1, 2'b10, 1'b0, 32'h40,
          32'h55AA55AA, 32'h300);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("wait_busy", busy_o[1] === 1'b1,
        busy_o[1], 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_req_ready", rdy_o[1] === 1'b1,
        rdy_o[1], 1'b1);
    chk("abort_busy", busy_o[1] === 1'b0,
        busy_o[1], 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_rsp", vld_o[1] === 1'b0,
          vld_o[1], 1'b0);
      @(posedge clk); #1;
    end
    txn(1, 0, 2'b10, 0, 32'h40, 32'h0,
        32'h304, 32'h0, 0, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0,
        32'h308, 32'h0, 0, 0, 0);

    txn(0, 1, 2'b10, 0, 32'h4, 32'hDEADBEEF,
        32'h3000, 32'h0, 0, 0, 0);
    txn(0, 0, 2'b10, 0, 32'h4, 32'h0,
        32'h3004, 32'hDEADBEEF, 0, 0, 0);

    chk("scoreboard_drained", sb.size() == 0,
        sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
